// File: rtl/spi_master_periph.sv
// Memory-mapped SPI master (mode 0, byte-wide, MSB first) with a 16-byte
// register window: CTRL, RXDATA, STATUS and CLKDIV.
module spi_master_periph #(
  parameter logic [31:0] BASE_ADDR   = 32'h2000_1000,
  parameter logic [7:0]  DEFAULT_DIV = 8'd4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        mem_valid,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wmask,
  output logic [31:0] mem_rdata,
  output logic        mem_ready,
  output logic        SPI_SCLK,
  output logic        SPI_MOSI,
  input  logic        SPI_MISO,
  output logic        SPI_CS_N
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned BIT_W  = 3;

  localparam logic [1:0] REG_CTRL = 2'd0;
  localparam logic [1:0] REG_RX   = 2'd1;
  localparam logic [1:0] REG_STAT = 2'd2;
  localparam logic [1:0] REG_DIV  = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_HIGH,
    ST_LOW,
    ST_HOLD
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [BYTE_W-1:0]   tx_q, tx_d;
  logic [BYTE_W-1:0]   rx_q, rx_d;
  logic [BYTE_W-1:0]   rxdata_q, rxdata_d;
  logic [BYTE_W-1:0]   txbyte_q, txbyte_d;
  logic [BYTE_W-1:0]   div_q, div_d;
  logic                en_q, en_d;
  logic                done_q, done_d;
  logic                ovr_q, ovr_d;
  logic                ready_q, ready_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                sclk_q, sclk_d;
  logic                mosi_q, mosi_d;
  logic                cs_n_q, cs_n_d;

  logic                hit_c;
  logic                wr_c;
  logic [1:0]          sel_c;
  logic                ctrl_wr_c;
  logic                rx_rd_c;
  logic                stat_wr_c;
  logic                div_wr_c;
  logic                busy_c;
  logic                en_new_c;
  logic [BYTE_W-1:0]   tx_new_c;
  logic                start_c;
  logic                go_c;
  logic                abort_c;
  logic [31:0]         rd_val_c;
  logic                unused_c;

  assign unused_c = ^{mem_addr[1:0], mem_wdata[31:16]};

  // Bus decode and the register values a CTRL store would leave behind
  assign hit_c     = mem_valid && !ready_q && (mem_addr[31:4] == BASE_ADDR[31:4]);
  assign wr_c      = |mem_wmask;
  assign sel_c     = mem_addr[3:2];
  assign ctrl_wr_c = hit_c && wr_c && (sel_c == REG_CTRL);
  assign rx_rd_c   = hit_c && !wr_c && (sel_c == REG_RX);
  assign stat_wr_c = hit_c && wr_c && (sel_c == REG_STAT);
  assign div_wr_c  = hit_c && wr_c && (sel_c == REG_DIV);
  assign busy_c    = (state_q != ST_IDLE);
  assign en_new_c  = (ctrl_wr_c && mem_wmask[0]) ? mem_wdata[0] : en_q;
  assign tx_new_c  = (ctrl_wr_c && mem_wmask[1]) ? mem_wdata[15:8] : txbyte_q;
  assign start_c   = ctrl_wr_c && mem_wmask[0] && mem_wdata[1] && en_new_c;
  assign go_c      = start_c && !busy_c;
  assign abort_c   = ctrl_wr_c && mem_wmask[0] && !mem_wdata[0] && busy_c;

  // Read mux reflects state before the committing edge
  always_comb begin
    rd_val_c = '0;
    case (sel_c)
      REG_CTRL: rd_val_c = {16'h0, txbyte_q, 6'h0, 1'b0, en_q};
      REG_RX:   rd_val_c = {24'h0, rxdata_q};
      REG_STAT: rd_val_c = {29'h0, ovr_q, done_q, busy_c};
      REG_DIV:  rd_val_c = {24'h0, div_q};
      default:  rd_val_c = '0;
    endcase
  end

  // Next-state: register writes, transfer sequencing and sticky flags
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    tx_d     = tx_q;
    rx_d     = rx_q;
    rxdata_d = rxdata_q;
    txbyte_d = tx_new_c;
    en_d     = en_new_c;
    done_d   = done_q;
    ovr_d    = ovr_q;
    div_d    = div_q;
    ready_d  = hit_c;
    rdata_d  = '0;
    sclk_d   = sclk_q;
    mosi_d   = mosi_q;
    cs_n_d   = cs_n_q;

    if (hit_c && !wr_c) rdata_d = rd_val_c;
    if (rx_rd_c) done_d = 1'b0;
    if (stat_wr_c && mem_wmask[0] && mem_wdata[2]) ovr_d = 1'b0;
    if (div_wr_c && mem_wmask[0]) div_d = mem_wdata[7:0];

    case (state_q)
      ST_IDLE: begin
        if (go_c) begin
          state_d = ST_SETUP;
          cs_n_d  = 1'b0;
          tx_d    = tx_new_c;
          mosi_d  = tx_new_c[7];
          cnt_d   = div_q;
          bit_d   = '0;
          done_d  = 1'b0;
        end
      end
      default: begin
        if (abort_c) begin
          state_d = ST_IDLE;
          cs_n_d  = 1'b1;
          sclk_d  = 1'b0;
          mosi_d  = 1'b0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          // Half-period boundary: a new CLKDIV is picked up here
          cnt_d = div_q;
          case (state_q)
            ST_SETUP: begin
              state_d = ST_HIGH;
              sclk_d  = 1'b1;
              rx_d    = {rx_q[6:0], SPI_MISO};
            end
            ST_HIGH: begin
              state_d = ST_LOW;
              sclk_d  = 1'b0;
              mosi_d  = tx_q[6];
              tx_d    = {tx_q[6:0], 1'b0};
            end
            ST_LOW: begin
              if (bit_q == BIT_W'(7)) begin
                state_d = ST_HOLD;
              end else begin
                state_d = ST_HIGH;
                bit_d   = bit_q + BIT_W'(1);
                sclk_d  = 1'b1;
                rx_d    = {rx_q[6:0], SPI_MISO};
              end
            end
            ST_HOLD: begin
              state_d  = ST_IDLE;
              cs_n_d   = 1'b1;
              mosi_d   = 1'b0;
              rxdata_d = rx_q;
              done_d   = 1'b1;
            end
            default: state_d = ST_IDLE;
          endcase
        end
      end
    endcase

    if (start_c && busy_c) ovr_d = 1'b1;
  end

  // State and output registers
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      tx_q     <= '0;
      rx_q     <= '0;
      rxdata_q <= '0;
      txbyte_q <= '0;
      en_q     <= 1'b0;
      done_q   <= 1'b0;
      ovr_q    <= 1'b0;
      div_q    <= DEFAULT_DIV;
      ready_q  <= 1'b0;
      rdata_q  <= '0;
      sclk_q   <= 1'b0;
      mosi_q   <= 1'b0;
      cs_n_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      tx_q     <= tx_d;
      rx_q     <= rx_d;
      rxdata_q <= rxdata_d;
      txbyte_q <= txbyte_d;
      en_q     <= en_d;
      done_q   <= done_d;
      ovr_q    <= ovr_d;
      div_q    <= div_d;
      ready_q  <= ready_d;
      rdata_q  <= rdata_d;
      sclk_q   <= sclk_d;
      mosi_q   <= mosi_d;
      cs_n_q   <= cs_n_d;
    end
  end

  assign mem_ready = ready_q;
  assign mem_rdata = rdata_q;
  assign SPI_SCLK  = sclk_q;
  assign SPI_MOSI  = mosi_q;
  assign SPI_CS_N  = cs_n_q;

endmodule

// File: tb/tb_spi_master_periph.sv
// Bench for spi_master_periph: random transfers, bus reads scored against a
// cycle-count register model, SPI pins scored by a pin monitor and slave.
module tb_spi_master_periph;

  localparam logic [31:0] A_CTRL = 32'h2000_1000;
  localparam logic [31:0] A_RX   = 32'h2000_1004;
  localparam logic [31:0] A_STAT = 32'h2000_1008;
  localparam logic [31:0] A_DIV  = 32'h2000_100C;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        mem_valid = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [3:0]  mem_wmask = '0;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        SPI_SCLK;
  logic        SPI_MOSI;
  logic        SPI_MISO = 1'b0;
  logic        SPI_CS_N;

  spi_master_periph dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .mem_valid (mem_valid),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wmask (mem_wmask),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .SPI_SCLK  (SPI_SCLK),
    .SPI_MOSI  (SPI_MOSI),
    .SPI_MISO  (SPI_MISO),
    .SPI_CS_N  (SPI_CS_N)
  );

  always #5 CLK = ~CLK;

  int unsigned cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int checks = 0;
  int passes = 0;
  int idle_rdata_bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: actual=0x%0h expected=0x%0h", nm, act, exp);
  endtask

  // Register model: transfer completion derived from start edge + 18 half-periods
  logic        m_en, m_done, m_ovr, m_busy;
  logic [7:0]  m_tx, m_rx, m_div, m_pat;
  int unsigned m_start, m_end;
  logic [7:0]  slv_pat = 8'h00;

  // Scoreboards
  logic [31:0] rd_val_q[$];
  logic        rd_chk_q[$];
  logic [3:0]  rd_off_q[$];
  int          sp_len_q[$];
  int          sp_hp_q[$];
  logic [7:0]  sp_tx_q[$];
  logic        sp_full_q[$];

  task automatic model_reset();
    if (m_busy && sp_len_q.size() > 0) begin
      sp_len_q[sp_len_q.size()-1]  = -1;
      sp_full_q[sp_full_q.size()-1] = 1'b0;
    end
    m_en = 0; m_done = 0; m_ovr = 0; m_busy = 0;
    m_tx = 0; m_rx = 0; m_div = 8'd4; m_pat = 0;
    m_start = 0; m_end = 0;
  endtask

  task automatic model_access(input int unsigned e, input logic [3:0] off,
                              input logic [31:0] wd, input logic [3:0] wm,
                              output logic [31:0] rv);
    logic nen;
    int   hp;
    if (m_busy && e > m_end) begin
      m_busy = 0; m_done = 1; m_rx = m_pat;
    end
    rv = '0;
    if (wm == 4'h0) begin
      case (off)
        4'h0: rv = {16'h0, m_tx, 7'h0, m_en};
        4'h4: begin rv = {24'h0, m_rx}; m_done = 0; end
        4'h8: rv = {29'h0, m_ovr, m_done, m_busy};
        default: rv = {24'h0, m_div};
      endcase
    end else begin
      case (off)
        4'h0: begin
          nen = wm[0] ? wd[0] : m_en;
          if (wm[1]) m_tx = wd[15:8];
          if (wm[0]) begin
            if (m_busy && !nen) begin
              m_busy = 0;
              sp_len_q[sp_len_q.size()-1]   = int'(e - m_start);
              sp_full_q[sp_full_q.size()-1] = 1'b0;
            end else if (wd[1] && nen) begin
              if (m_busy) m_ovr = 1;
              else begin
                hp = int'(m_div) + 1;
                m_busy = 1; m_done = 0; m_start = e;
                m_end = e + 18 * hp; m_pat = slv_pat;
                sp_len_q.push_back(18 * hp);
                sp_hp_q.push_back(hp);
                sp_tx_q.push_back(m_tx);
                sp_full_q.push_back(1'b1);
              end
            end
          end
          m_en = nen;
        end
        4'h8: if (wm[0] && wd[2]) m_ovr = 0;
        4'hC: if (wm[0]) m_div = wd[7:0];
        default: ;
      endcase
    end
  endtask

  // One bus access; expected read data queued before the commit edge
  task automatic bus(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] wm);
    logic [31:0] rv;
    int n;
    @(negedge CLK);
    mem_valid = 1; mem_addr = a; mem_wdata = wd; mem_wmask = wm;
    model_access(cyc + 1, a[3:0] & 4'hC, wd, wm, rv);
    rd_val_q.push_back(rv);
    rd_chk_q.push_back(wm == 4'h0);
    rd_off_q.push_back(a[3:0]);
    n = 0;
    do begin @(negedge CLK); n++; end while (!mem_ready && n < 8);
    check("bus_ready", {31'h0, mem_ready}, 32'h1);
    mem_valid = 0; mem_wmask = 0;
  endtask

  task automatic rd(input logic [31:0] a);
    bus(a, 32'h0, 4'h0);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (SPI_CS_N == 1'b0 && n < 3000) begin @(negedge CLK); n++; end
    check("cs_release", {31'h0, SPI_CS_N}, 32'h1);
  endtask

  // Bus monitor: pops expected read data on every completion pulse
  logic [31:0] mv;
  logic        mc;
  logic [3:0]  mo;
  always @(negedge CLK) begin
    if (!RESET) begin
      if (mem_ready) begin
        if (rd_val_q.size() == 0) check("bus_unexpected_ready", 32'h1, 32'h0);
        else begin
          mv = rd_val_q.pop_front();
          mc = rd_chk_q.pop_front();
          mo = rd_off_q.pop_front();
          if (mc) check($sformatf("read_off_%0h", mo), mem_rdata, mv);
        end
      end else if (mem_rdata != 32'h0) idle_rdata_bad++;
    end
  end

  // SPI slave (drives MISO) and pin monitor
  logic       cs_prev = 1'b1, sclk_prev = 1'b0;
  logic [7:0] slv_sr = 8'h00, mosi_cap = 8'h00;
  int cs_len = 0, rises = 0, first_r = -1, last_r = -1;
  int e_len, e_hp;
  logic [7:0] e_tx;
  logic e_full;
  always @(negedge CLK) begin
    if (cs_prev && !SPI_CS_N) begin
      slv_sr = slv_pat; cs_len = 0; rises = 0; mosi_cap = 0; first_r = -1; last_r = -1;
    end else if (!SPI_CS_N && sclk_prev && !SPI_SCLK) begin
      slv_sr = {slv_sr[6:0], 1'b0};
    end
    SPI_MISO = slv_sr[7];
    if (!SPI_CS_N) begin
      if (!sclk_prev && SPI_SCLK) begin
        rises++;
        mosi_cap = {mosi_cap[6:0], SPI_MOSI};
        if (first_r < 0) first_r = cs_len;
        last_r = cs_len;
      end
      cs_len++;
    end
    if (!cs_prev && SPI_CS_N) begin
      if (sp_len_q.size() == 0) check("spi_unexpected_frame", 32'h1, 32'h0);
      else begin
        e_len = sp_len_q.pop_front(); e_hp = sp_hp_q.pop_front();
        e_tx = sp_tx_q.pop_front(); e_full = sp_full_q.pop_front();
        if (e_len >= 0) check("spi_cs_low_cycles", 32'(cs_len), 32'(e_len));
        if (e_full) begin
          check("spi_sclk_pulses", 32'(rises), 32'd8);
          check("spi_mosi_byte", {24'h0, mosi_cap}, {24'h0, e_tx});
          check("spi_first_rise", 32'(first_r), 32'(e_hp));
          check("spi_sclk_period", 32'(last_r - first_r), 32'(14 * e_hp));
        end
      end
    end
    cs_prev = SPI_CS_N;
    sclk_prev = SPI_SCLK;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d, tx, tx2, pat;
    int seen;
    model_reset();

    // Reset values
    repeat (5) @(posedge CLK);
    @(negedge CLK);
    check("rst_mem_ready", {31'h0, mem_ready}, 32'h0);
    check("rst_mem_rdata", mem_rdata, 32'h0);
    check("rst_cs_n", {31'h0, SPI_CS_N}, 32'h1);
    check("rst_sclk", {31'h0, SPI_SCLK}, 32'h0);
    check("rst_mosi", {31'h0, SPI_MOSI}, 32'h0);
    RESET = 0;
    rd(A_DIV); rd(A_STAT); rd(A_CTRL); rd(A_RX);

    // Basic transfer with MISO pattern 0xA5
    slv_pat = 8'hA5;
    bus(A_CTRL, 32'h0000_0103, 4'hF);
    wait_idle();
    rd(A_STAT); rd(A_RX); rd(A_STAT);

    // Fastest divider
    bus(A_DIV, 32'h0, 4'hF);
    slv_pat = 8'($urandom);
    bus(A_CTRL, 32'h0000_FF03, 4'hF);
    wait_idle();
    rd(A_STAT); rd(A_RX); rd(A_STAT);

    // Overrun: second START 10 cycles in
    bus(A_DIV, 32'h4, 4'h1);
    tx = 8'($urandom); tx2 = 8'($urandom); slv_pat = 8'($urandom);
    bus(A_CTRL, {16'h0, tx, 8'h03}, 4'hF);
    repeat (10) @(negedge CLK);
    bus(A_CTRL, {16'h0, tx2, 8'h03}, 4'hF);
    rd(A_STAT);
    wait_idle();
    rd(A_STAT);
    bus(A_STAT, 32'h4, 4'h1);
    rd(A_STAT); rd(A_RX); rd(A_STAT);

    // Abort mid-transfer
    slv_pat = 8'($urandom);
    bus(A_CTRL, {16'h0, 8'($urandom), 8'h03}, 4'hF);
    repeat (30) @(negedge CLK);
    bus(A_CTRL, 32'h0, 4'hF);
    check("abort_cs_n", {31'h0, SPI_CS_N}, 32'h1);
    check("abort_sclk", {31'h0, SPI_SCLK}, 32'h0);
    rd(A_STAT); rd(A_RX);

    // Out-of-window read gets no response
    @(negedge CLK);
    mem_valid = 1; mem_addr = 32'h2000_2000; mem_wmask = 0;
    seen = 0;
    repeat (10) begin @(negedge CLK); if (mem_ready) seen++; end
    check("oow_no_ready", 32'(seen), 32'h0);
    mem_valid = 0;

    // Lane-1-only CTRL write: TXBYTE only, no start
    bus(A_CTRL, 32'h0000_5503, 4'h2);
    repeat (5) @(negedge CLK);
    check("lane1_no_start", {31'h0, SPI_CS_N}, 32'h1);
    rd(A_CTRL); rd(A_STAT);

    // START with EN=0 is ignored without flags
    bus(A_CTRL, 32'h0000_3302, 4'hF);
    repeat (5) @(negedge CLK);
    check("start_en0_no_cs", {31'h0, SPI_CS_N}, 32'h1);
    rd(A_STAT);

    // Random transfers with a STATUS poll at a random point
    for (int i = 0; i < 6; i++) begin
      d = 8'($urandom_range(0, 3));
      tx = 8'($urandom); pat = 8'($urandom);
      bus(A_DIV, {24'h0, d}, 4'hF);
      slv_pat = pat;
      bus(A_CTRL, {16'h0, tx, 8'h03}, 4'hF);
      repeat ($urandom_range(0, 40)) @(negedge CLK);
      rd(A_STAT);
      wait_idle();
      rd(A_RX); rd(A_STAT);
    end

    // Reset asserted mid-transfer
    bus(A_DIV, 32'h4, 4'hF);
    slv_pat = 8'($urandom);
    bus(A_CTRL, {16'h0, 8'($urandom), 8'h03}, 4'hF);
    repeat (20) @(negedge CLK);
    @(posedge CLK);
    #1;
    model_reset();
    RESET = 1;
    #1;
    check("midrst_cs_n", {31'h0, SPI_CS_N}, 32'h1);
    check("midrst_sclk", {31'h0, SPI_SCLK}, 32'h0);
    check("midrst_ready", {31'h0, mem_ready}, 32'h0);
    repeat (3) @(negedge CLK);
    RESET = 0;
    rd(A_DIV); rd(A_STAT); rd(A_RX); rd(A_CTRL);

    repeat (5) @(negedge CLK);
    check("rd_queue_drained", 32'(rd_val_q.size()), 32'h0);
    check("spi_queue_drained", 32'(sp_len_q.size()), 32'h0);
    check("idle_rdata_zero", 32'(idle_rdata_bad), 32'h0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/spi_master_periph.md
# spi_master_periph

Memory-mapped SPI master peripheral attached to the SOC data bus at 0x2000_1000. It decodes CPU load/store requests, holds the control, data, status and divider registers, and runs byte-wide SPI mode-0 transfers on the external pins. It is the bus-side consumer of CPU stores that start a transfer, and it produces received bytes and status for CPU polling.

## Interface
- BASE_ADDR, 32'h2000_1000: base of the 16-byte register window. Decode matches addr[31:4] only.
- DEFAULT_DIV, 8'd4: reset value of CLKDIV.

Ports:
- CLK  in  1: system clock.
- RESET  in  1: asynchronous, active-high reset.
- mem_valid  in  1: bus request. Held by the master until mem_ready.
- mem_addr  in  32: byte address. Bits [1:0] are ignored.
- mem_wdata  in  32: store data.
- mem_wmask  in  4: byte-lane write enables. 0 means a read.
- mem_rdata  out  32: read data. Valid only while mem_ready is high, 0 otherwise.
- mem_ready  out  1: one-cycle completion pulse.
- SPI_SCLK  out  1: serial clock, idle low.
- SPI_MOSI  out  1: serial data out, MSB first.
- SPI_MISO  in  1: serial data in.
- SPI_CS_N  out  1: chip select, active low.

## Operation
- Registers (offset from BASE_ADDR):
  - 0x0 CTRL:
    - [0] EN.
    - [1] START: write-1 pulse; always reads 0.
    - [15:8] TXBYTE.
    - Other bits read 0.
  - 0x4 RXDATA: [7:0] last received byte. Read-only. A read clears STATUS.DONE.
  - 0x8 STATUS:
    - [0] BUSY.
    - [1] DONE: sticky.
    - [2] OVERRUN: sticky; write-1-to-clear.
  - 0xC CLKDIV: [7:0]. SCLK half-period is CLKDIV+1 CLK cycles.
- Byte lanes: only lanes with mem_wmask set update register bits. START and EN take effect only if lane 0 is written.
- Start condition: a write with START=1 while the resulting EN=1 (the EN value written in the same store counts) and BUSY=0. On that commit edge:
  - latch TXBYTE into the shift register;
  - set BUSY, clear DONE;
  - enter SETUP.
- START=1 while BUSY=1: ignored, sets OVERRUN.
- START=1 with resulting EN=0: ignored, no flag set.
- FSM states:
  - IDLE: CS_N=1, SCLK=0.
  - SETUP: CS_N=0, MOSI=bit7, one half-period.
  - HIGH: SCLK=1. Sample MISO on entry edge. Lasts one half-period.
  - LOW: SCLK=0. Shift MOSI to the next bit. Lasts one half-period. HIGH/LOW repeat 8 times.
  - HOLD: SCLK=0, one half-period after the 8th LOW.
  - Then back to IDLE: CS_N=1, RXDATA updated, DONE=1, BUSY=0, all on the same edge.
- Abort: EN written 0 while BUSY:
  - return to IDLE on the next edge, with CS_N=1 and SCLK=0;
  - BUSY=0; DONE and RXDATA unchanged.
- CLKDIV writes during a transfer take effect at the next half-period boundary.
- Out-of-window addresses: ignored; mem_ready stays 0.

## Timing
- Reset values:
  - mem_ready=0, mem_rdata=0;
  - SPI_CS_N=1, SPI_SCLK=0, SPI_MOSI=0;
  - CTRL=0, RXDATA=0, STATUS=0, CLKDIV=DEFAULT_DIV, FSM=IDLE.
- Bus handshake:
  - mem_valid high and mem_ready low at an edge, with address in window: access committed at that edge.
  - mem_ready=1 for exactly the following cycle, with mem_rdata driven.
  - A new access is accepted only when mem_ready=0, so the minimum back-to-back access is 2 cycles.
- Read values reflect register state before the committing edge.
- Transfer timing:
  - SPI_CS_N falls on the start commit edge.
  - SPI_CS_N is low for 18 half-periods, i.e. 18×(CLKDIV+1) cycles. With DEFAULT_DIV this is 90 cycles.
  - First SCLK rise comes 1 half-period after CS_N falls.
- Simultaneous events:
  - RXDATA read on the same edge that sets DONE: DONE ends at 1 (set wins).
  - OVERRUN set and clear on the same edge: set wins.
- RESET asserted mid-transfer: immediate return to all reset values, no pin glitch beyond CS_N going high.

## Test plan
- Reset check: assert RESET for 5 cycles -> all outputs at reset values; CLKDIV reads 4; STATUS reads 0.
- Basic transfer: write 0x0000_0103 to 0x2000_1000 with MISO tied to pattern 0xA5 -> MOSI shifts 0x01 MSB first; CS_N low for 90 cycles; 8 SCLK pulses; STATUS reads 0x2; RXDATA reads 0xA5; a following STATUS read gives 0x0.
- Divider: write CLKDIV=0, then start with TXBYTE=0xFF -> SCLK period is 2 cycles; CS_N low for 18 cycles.
- Overrun: issue a second START 10 cycles into a transfer -> transfer continues unaffected; STATUS reads 0x5; writing 0x4 to STATUS clears OVERRUN.
- Abort: write CTRL=0 mid-transfer -> CS_N high next cycle; BUSY=0; DONE=0; RXDATA unchanged.
- Bus: read from 0x2000_2000 -> no mem_ready within 10 cycles. Write only lane 1 of CTRL with 0x0000_5503 -> TXBYTE=0x55; no start occurs; EN stays 0.
